pe_cmd_sequencer: RTL
=====================

# pe_cmd_sequencer

Per-PE command sequencer that sits directly upstream of `PE_top` and drives its instruction port. It accepts one convolution job descriptor (P, Q, S, options) and issues the PE command chain SET → LOAD_IFMAP → LOAD_WGHT → CONV → optional ACC. Between commands it waits for the PE to return to idle. On completion it reports done, and it counts jobs for the array-level controller.

## Interface
Parameters:
- `DIM_BITWIDTH`, 3, width of each of P, Q, S.
- `JOB_CNT_BITWIDTH`, 16, width of the completed-job counter.

Ports:
- `i_clk`  in  1  the single clock.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_job_valid`  in  1  job descriptor valid.
- `o_job_ready`  out  1  sequencer idle, can accept a job.
- `i_job_p`, `i_job_q`, `i_job_s`  in  DIM_BITWIDTH each  conv dimensions.
- `i_job_acc`  in  1  issue CMD_ACC after CONV.
- `i_job_wght_reuse`  in  1  skip LOAD_WGHT (see Configuration).
- `o_inst_data`  out  3  PE command code.
- `o_conv_info`  out  3*DIM_BITWIDTH  {P,Q,S}, with P in the MSBs.
- `o_inst_valid`  out  1  command valid.
- `i_inst_ready`  in  1  PE idle / accepting.
- `o_busy`  out  1  job in progress.
- `o_done`  out  1  one-cycle pulse when a job completes.
- `o_err`  out  1  one-cycle pulse when a job is rejected.
- `o_job_cnt`  out  JOB_CNT_BITWIDTH  count of completed jobs; wraps.

## Operation
- Command codes: NOP=0, SET=1, LOAD_IFMAP=2, LOAD_WGHT=3, CONV=4, ACC=5.
- States:
  - IDLE → ISSUE on job accept (`i_job_valid && o_job_ready`).
  - ISSUE → GUARD on command accept (`o_inst_valid && i_inst_ready`).
  - GUARD → WAIT unconditionally after one cycle. This covers the PE's DEC cycle; `i_inst_ready` is ignored during GUARD.
  - WAIT → ISSUE (next command) or DONE once `i_inst_ready` is sampled high.
  - DONE → IDLE after one cycle.
- Descriptor handling on accept:
  - The descriptor is registered. `o_conv_info` holds {P,Q,S} for the whole job and is cleared to 0 in IDLE.
  - If any of P, Q, S is 0, no command is issued. `o_err` pulses on the cycle after accept, the FSM returns to IDLE, and `o_job_cnt` is unchanged.
- Command chain: SET, LOAD_IFMAP, LOAD_WGHT (unless skipped), CONV, then ACC if `i_job_acc`.
- `o_inst_data` outputs NOP whenever `o_inst_valid`=0.
- In ISSUE, `o_inst_valid`=1 and `o_inst_data` is held stable until the handshake completes; valid never drops without a handshake.
- DONE: `o_done`=1 and `o_job_cnt` increments, wrapping from all-ones to 0.
- `o_job_ready`=1 only in IDLE.
- `o_busy`=1 in ISSUE, GUARD, WAIT and DONE.
- Signals that are not handshakes are ignored: `i_job_valid` outside IDLE, and `i_inst_ready` rising in ISSUE before valid.

## Timing
- Reset values (asynchronous, on assertion of `i_rst_n`=0): state=IDLE, `o_inst_valid`=0, `o_inst_data`=NOP, `o_conv_info`=0, `o_busy`=0, `o_done`=0, `o_err`=0, `o_job_cnt`=0, `o_job_ready`=1.
- Reset mid-job: the job is aborted with no done pulse, and `o_inst_valid` drops immediately.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- Job accept at cycle T → SET valid at T+1.
- Command handshake at cycle A → GUARD at A+1 → `i_inst_ready` sampled from A+2 onward.
- Ready sampled high at cycle B → next command valid at B+1, or DONE at B+1.
- Minimum job length: 3 cycles per command plus 1 DONE cycle.
  - Full 4-command job: 13 cycles from the first valid to `o_done`.
  - With ACC: 16 cycles.
- Back-to-back jobs: the earliest next accept is the cycle after DONE, i.e. `o_job_ready` is high in the cycle following the `o_done` pulse.

## Configuration
- Macro: `PE_SEQ_WGHT_REUSE_EN`.
- Defined: `i_job_wght_reuse`=1 skips LOAD_WGHT, so the chain goes LOAD_IFMAP → CONV.
- Undefined: `i_job_wght_reuse` is ignored and LOAD_WGHT is always issued. The port stays present.

## Structure
- Shared package `pe_pkg` holds:
  - the CMD_* constants (3-bit);
  - the sequencer state enum {IDLE, ISSUE, GUARD, WAIT, DONE};
  - the conv_info field offsets (P=[8:6], Q=[5:3], S=[2:0]).
- `PE_top` must import the same package.
- No sub-module. The next-command selection is a small combinational function inside the block.

## Test plan
- Job P=6, Q=4, S=3, acc=0, with a PE model holding ready low for 5 cycles per command → commands issued in order SET(`o_conv_info`=9'h1A3), LOAD_IFMAP, LOAD_WGHT, CONV; one `o_done` pulse; `o_job_cnt`=1.
- Same job with acc=1 → ACC issued after CONV; `o_done` pulse 16 cycles after the first valid when ready is always high.
- With `PE_SEQ_WGHT_REUSE_EN` defined and reuse=1 → no LOAD_WGHT (code 3) seen. Undefined with reuse=1 → LOAD_WGHT is issued.
- Job with S=0 → `o_err` pulse at T+1; `o_inst_valid` never goes high; `o_job_cnt` unchanged.
- Hold `i_inst_ready` low for 20 cycles during ISSUE of CONV → `o_inst_valid`=1 and `o_inst_data`=4 stable throughout. Pulsing ready during GUARD → no early advance.
- Assert `i_rst_n`=0 mid-CONV → all outputs at reset values immediately; a new job is accepted cleanly after release. Preload `o_job_cnt`=16'hFFFF and complete one job → wraps to 0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared PE definitions: command codes, sequencer state encoding and the
// conv_info field layout used by both the sequencer and PE_top.
package pe_pkg;

    localparam logic [2:0] CMD_NOP        = 3'd0;
    localparam logic [2:0] CMD_SET        = 3'd1;
    localparam logic [2:0] CMD_LOAD_IFMAP = 3'd2;
    localparam logic [2:0] CMD_LOAD_WGHT  = 3'd3;
    localparam logic [2:0] CMD_CONV       = 3'd4;
    localparam logic [2:0] CMD_ACC        = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        GUARD = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    localparam int CONV_P_MSB = 8;
    localparam int CONV_P_LSB = 6;
    localparam int CONV_Q_MSB = 5;
    localparam int CONV_Q_LSB = 3;
    localparam int CONV_S_MSB = 2;
    localparam int CONV_S_LSB = 0;

endpackage

// File: rtl/pe_cmd_sequencer_if.sv
// Job-descriptor, PE-instruction and status signals of the PE command sequencer.
// master = sequencer side, slave = job source / PE side.
interface pe_cmd_sequencer_if #(
    parameter int DIM_BITWIDTH     = 3,
    parameter int JOB_CNT_BITWIDTH = 16
);
    logic                          i_job_valid;
    logic                          o_job_ready;
    logic [DIM_BITWIDTH-1:0]       i_job_p;
    logic [DIM_BITWIDTH-1:0]       i_job_q;
    logic [DIM_BITWIDTH-1:0]       i_job_s;
    logic                          i_job_acc;
    logic                          i_job_wght_reuse;
    logic [2:0]                    o_inst_data;
    logic [3*DIM_BITWIDTH-1:0]     o_conv_info;
    logic                          o_inst_valid;
    logic                          i_inst_ready;
    logic                          o_busy;
    logic                          o_done;
    logic                          o_err;
    logic [JOB_CNT_BITWIDTH-1:0]   o_job_cnt;

    modport master (
        input  i_job_valid, i_job_p, i_job_q, i_job_s, i_job_acc, i_job_wght_reuse,
        input  i_inst_ready,
        output o_job_ready, o_inst_data, o_conv_info, o_inst_valid,
        output o_busy, o_done, o_err, o_job_cnt
    );

    modport slave (
        output i_job_valid, i_job_p, i_job_q, i_job_s, i_job_acc, i_job_wght_reuse,
        output i_inst_ready,
        input  o_job_ready, o_inst_data, o_conv_info, o_inst_valid,
        input  o_busy, o_done, o_err, o_job_cnt
    );

endinterface

// File: rtl/pe_cmd_sequencer.sv
// Per-PE command sequencer: turns one conv job into SET/LOAD_IFMAP/LOAD_WGHT/CONV[/ACC].
// Optional PE_SEQ_WGHT_REUSE_EN lets i_job_wght_reuse skip LOAD_WGHT.
module pe_cmd_sequencer
    import pe_pkg::*;
#(
    parameter int DIM_BITWIDTH     = 3,
    parameter int JOB_CNT_BITWIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    pe_cmd_sequencer_if.master   bus
);

    seq_state_e                    state_q, state_d;
    logic [2:0]                    cmd_q, cmd_d;
    logic [3*DIM_BITWIDTH-1:0]     info_q, info_d;
    logic                          acc_q, acc_d;
    logic                          reuse_q, reuse_d;
    logic                          err_q, err_d;
    logic [JOB_CNT_BITWIDTH-1:0]   cnt_q, cnt_d;
    logic [2:0]                    nxt_cmd;
    logic                          dim_zero;

    // Successor in the command chain; NOP means the chain is finished.
    function automatic logic [2:0] next_cmd(input logic [2:0] cur,
                                            input logic       acc,
                                            input logic       skip_wght);
        logic [2:0] n;
        n = CMD_NOP;
        case (cur)
            CMD_SET:        n = CMD_LOAD_IFMAP;
            CMD_LOAD_IFMAP: n = skip_wght ? CMD_CONV : CMD_LOAD_WGHT;
            CMD_LOAD_WGHT:  n = CMD_CONV;
            CMD_CONV:       n = acc ? CMD_ACC : CMD_NOP;
            default:        n = CMD_NOP;
        endcase
        return n;
    endfunction

    assign dim_zero = (bus.i_job_p == '0) || (bus.i_job_q == '0) || (bus.i_job_s == '0);
    assign nxt_cmd  = next_cmd(cmd_q, acc_q, reuse_q);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        info_d  = info_q;
        acc_d   = acc_q;
        reuse_d = reuse_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_job_valid) begin
                    if (dim_zero) begin
                        err_d = 1'b1;
                    end else begin
                        info_d  = {bus.i_job_p, bus.i_job_q, bus.i_job_s};
                        acc_d   = bus.i_job_acc;
`ifdef PE_SEQ_WGHT_REUSE_EN
                        reuse_d = bus.i_job_wght_reuse;
`else
                        reuse_d = 1'b0;
`endif
                        cmd_d   = CMD_SET;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.i_inst_ready) state_d = GUARD;
            end
            // PE is decoding the command here; its ready is not trustworthy yet.
            GUARD: state_d = WAIT;
            WAIT: begin
                if (bus.i_inst_ready) begin
                    if (nxt_cmd == CMD_NOP) begin
                        state_d = DONE;
                    end else begin
                        cmd_d   = nxt_cmd;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                cnt_d   = cnt_q + {{(JOB_CNT_BITWIDTH-1){1'b0}}, 1'b1};
                info_d  = '0;
                cmd_d   = CMD_NOP;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cmd_q   <= CMD_NOP;
            info_q  <= '0;
            acc_q   <= 1'b0;
            reuse_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            info_q  <= info_d;
            acc_q   <= acc_d;
            reuse_q <= reuse_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_inst_valid = (state_q == ISSUE);
    assign bus.o_inst_data  = (state_q == ISSUE) ? cmd_q : CMD_NOP;
    assign bus.o_conv_info  = info_q;
    assign bus.o_job_ready  = (state_q == IDLE);
    assign bus.o_busy       = (state_q != IDLE);
    assign bus.o_done       = (state_q == DONE);
    assign bus.o_err        = err_q;
    assign bus.o_job_cnt    = cnt_q;

endmodule
